// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write arbiter: FSM state encoding,
// the lcd_control data width and the default watchdog limit.
package lcd_pkg;

    localparam int LCD_DATA_W          = 8;
    localparam int LCD_TIMEOUT_DEFAULT = 65535;

    // WAIT_INIT is encoded as zero so the debug state reads 0 in reset.
    typedef enum logic [2:0] {
        ST_WAIT_INIT  = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_CLEAR      = 3'd4,
        ST_CLEAR_WAIT = 3'd5
    } lcd_state_e;

endpackage

// File: rtl/lcd_req_picker.sv
// Combinational winner selection for lcd_write_arbiter.
// Build option LCD_ARB_ROUND_ROBIN_EN: search starts after ptr; otherwise lowest index wins.
module lcd_req_picker
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Returns {found, index of lowest set bit}.
    function automatic logic [IDX_W:0] first_set(input logic [NUM_REQ-1:0] v);
        first_set = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                first_set = {1'b1, IDX_W'(i)};
            end
        end
    endfunction

`ifdef LCD_ARB_ROUND_ROBIN_EN
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [NUM_REQ-1:0]   rot_req;
    logic [IDX_W:0]       start;
    logic [IDX_W:0]       hit;
    logic [IDX_W:0]       sum;

    // Rotate so bit 0 of rot_req is requester ptr+1, then map the hit back.
    always_comb begin
        start   = {1'b0, ptr} + 1'b1;
        dbl_req = {req, req};
        rot_req = NUM_REQ'(dbl_req >> start);
        hit     = first_set(rot_req);
        sum     = start + {1'b0, hit[IDX_W-1:0]};
        valid   = hit[IDX_W];
        if (sum >= NUM_REQ_W) begin
            idx = IDX_W'(sum - NUM_REQ_W);
        end else begin
            idx = IDX_W'(sum);
        end
    end
`else
    logic [IDX_W:0] hit;
    logic           unused_ptr;

    always_comb begin
        hit   = first_set(req);
        idx   = hit[IDX_W-1:0];
        valid = hit[IDX_W];
    end

    assign unused_ptr = |ptr;
`endif

endmodule

// File: rtl/lcd_write_arbiter.sv
// Arbitrates NUM_REQ byte writers plus a display-clear request onto one lcd_control.
// Build option LCD_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = LCD_TIMEOUT_DEFAULT
) (
    input  logic                          I_CLK,
    input  logic                          I_RST,
    input  logic [NUM_REQ-1:0]            I_REQ,
    input  logic [NUM_REQ*LCD_DATA_W-1:0] I_DATA,
    input  logic                          I_CLEAR_REQ,
    input  logic                          I_INIT_DONE,
    input  logic                          I_WRITE_DONE,
    output logic                          O_WRITE_START,
    output logic [LCD_DATA_W-1:0]         O_DATA,
    output logic                          O_CLEAR,
    output logic [NUM_REQ-1:0]            O_ACK,
    output logic [$clog2(NUM_REQ)-1:0]    O_OWNER,
    output logic                          O_BUSY,
    output logic                          O_TIMEOUT,
    output logic [2:0]                    O_DBG_STATE
);

    localparam int             IDX_W   = $clog2(NUM_REQ);
    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    lcd_state_e            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [LCD_DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  pending_q, pending_d;
    logic                  start_q, start_d;
    logic                  clear_q, clear_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;

    logic                  clear_now;
    logic [NUM_REQ-1:0]    req_eff;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    // No grant on the cycle O_ACK is visible: the acked requester has not yet
    // had a chance to drop I_REQ, so its level would be a stale request.
    assign req_eff = (|ack_q) ? '0 : I_REQ;

    lcd_req_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_eff),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        start_d   = 1'b0;
        clear_d   = 1'b0;
        ack_d     = '0;
        timeout_d = 1'b0;
        clear_now = pending_q | I_CLEAR_REQ;
        pending_d = clear_now;

        case (state_q)
            ST_WAIT_INIT: begin
                if (I_INIT_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_now) begin
                    pending_d = 1'b0;
                    state_d   = ST_CLEAR;
                end else if (pick_valid) begin
                    owner_d = pick_idx;
                    data_d  = I_DATA[LCD_DATA_W*pick_idx +: LCD_DATA_W];
`ifdef LCD_ARB_ROUND_ROBIN_EN
                    ptr_d   = pick_idx;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done on the terminal-count cycle still wins over the watchdog.
                if (I_WRITE_DONE) begin
                    ack_d[owner_q] = 1'b1;
                    state_d        = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                clear_d = 1'b1;
                wd_d    = '0;
                state_d = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                if (I_WRITE_DONE) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase

        // Losing initDone abandons whatever is in flight but keeps a queued clear.
        if (state_q != ST_WAIT_INIT && !I_INIT_DONE) begin
            state_d   = ST_WAIT_INIT;
            owner_d   = owner_q;
            data_d    = data_q;
            ptr_d     = ptr_q;
            start_d   = 1'b0;
            clear_d   = 1'b0;
            ack_d     = '0;
            timeout_d = 1'b0;
            pending_d = clear_now;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q   <= ST_WAIT_INIT;
            owner_q   <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            pending_q <= 1'b0;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            pending_q <= pending_d;
            start_q   <= start_d;
            clear_q   <= clear_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign O_WRITE_START = start_q;
    assign O_DATA        = data_q;
    assign O_CLEAR       = clear_q;
    assign O_ACK         = ack_q;
    assign O_OWNER       = owner_q;
    assign O_BUSY        = busy_q;
    assign O_TIMEOUT     = timeout_q;
    assign O_DBG_STATE   = state_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed self-checking bench for lcd_write_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_lcd_write_arbiter;
    import lcd_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        clear_req;
    logic        init_done;
    logic        write_done;
    logic        o_write_start;
    logic [7:0]  o_data;
    logic        o_clear;
    logic [3:0]  o_ack;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic        o_timeout;
    logic [2:0]  o_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    lcd_write_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (16)
    ) dut (
        .I_CLK         (clk),
        .I_RST         (rst),
        .I_REQ         (req),
        .I_DATA        (data),
        .I_CLEAR_REQ   (clear_req),
        .I_INIT_DONE   (init_done),
        .I_WRITE_DONE  (write_done),
        .O_WRITE_START (o_write_start),
        .O_DATA        (o_data),
        .O_CLEAR       (o_clear),
        .O_ACK         (o_ack),
        .O_OWNER       (o_owner),
        .O_BUSY        (o_busy),
        .O_TIMEOUT     (o_timeout),
        .O_DBG_STATE   (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (o_write_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, o_write_start, 1);
    endtask

    task automatic ack_cycle(input string tag, input logic [3:0] exp);
        write_done = 1'b1;
        step();
        check(tag, o_ack, exp);
        write_done = 1'b0;
    endtask

    int order[4];
    int n_grants;

    initial begin
        rst = 1'b1; req = '0; data = '0; clear_req = 1'b0;
        init_done = 1'b0; write_done = 1'b0;
        step(); step();
        check("rst_outs", {o_write_start, o_clear, o_ack, o_owner, o_busy, o_timeout}, 0);
        check("rst_data", o_data, 0);
        check("rst_state", o_dbg_state, ST_WAIT_INIT);

        rst = 1'b0;
        step();
        check("wait_init_busy", o_busy, 1);
        init_done = 1'b1;
        step();
        check("idle_state", o_dbg_state, ST_IDLE);
        check("idle_busy", o_busy, 0);

        // Single write: start two edges after the request, data held afterwards.
        req = 4'b0001; data[7:0] = 8'h48;
        step();
        check("grant_no_start_yet", o_write_start, 0);
        check("issue_state", o_dbg_state, ST_ISSUE);
        step();
        check("start_latency", o_write_start, 1);
        check("start_data", o_data, 8'h48);
        data[7:0] = 8'h99;
        step();
        check("start_one_cycle", o_write_start, 0);
        check("data_stable", o_data, 8'h48);
        ack_cycle("ack_req0", 4'b0001);
        check("ack_back_idle", o_dbg_state, ST_IDLE);
        req = '0;
        step();
        check("ack_one_cycle", o_ack, 0);

        // All four requesting continuously.
        data = 32'h13121110;
        req = 4'b1111;
`ifdef LCD_ARB_ROUND_ROBIN_EN
        order = '{1, 2, 3, 0};
        n_grants = 4;
`else
        order = '{0, 0, 0, 0};
        n_grants = 3;
`endif
        for (int g = 0; g < n_grants; g++) begin
            wait_start("order_start");
            check("order_owner", o_owner, order[g]);
            check("order_data", o_data, 8'h10 + order[g]);
            ack_cycle("order_ack", 4'b0001 << order[g]);
        end
        req = '0;
        step(); step();
        check("order_idle", o_dbg_state, ST_IDLE);

        // Clear raised mid-write; requester 2 drops its request but is still acked.
        data = 32'h0000_5A00 | 32'h005A_0000;
        data[15:8] = 8'h21;
        req = 4'b0100;
        wait_start("clr_start");
        check("clr_owner", o_owner, 2);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        req = 4'b0010;
        check("clr_not_yet", o_clear, 0);
        step();
        check("clr_no_ack_yet", o_ack, 0);
        ack_cycle("clr_ack_req2", 4'b0100);
        step();
        check("clr_state", o_dbg_state, ST_CLEAR);
        step();
        check("clr_pulse", o_clear, 1);
        check("clr_no_start", o_write_start, 0);
        step();
        check("clr_pulse_end", o_clear, 0);
        check("clr_wait_state", o_dbg_state, ST_CLEAR_WAIT);
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("clr_done_no_ack", o_ack, 0);
        check("clr_done_idle", o_dbg_state, ST_IDLE);
        wait_start("after_clr_start");
        check("after_clr_owner", o_owner, 1);
        check("after_clr_data", o_data, 8'h21);
        ack_cycle("after_clr_ack", 4'b0010);
        req = '0;
        step();

        // Watchdog expiry with writeDone never arriving.
        req = 4'b1000;
        wait_start("wd_start");
        for (int k = 0; k < 15; k++) step();
        check("wd_not_early", o_timeout, 0);
        step();
        check("wd_pulse", o_timeout, 1);
        check("wd_no_ack", o_ack, 0);
        check("wd_idle", o_dbg_state, ST_IDLE);
        req = '0;
        step();
        check("wd_pulse_end", o_timeout, 0);

        // writeDone on the terminal-count cycle counts as success.
        req = 4'b0001;
        wait_start("wd_edge_start");
        for (int k = 0; k < 15; k++) step();
        ack_cycle("wd_edge_ack", 4'b0001);
        check("wd_edge_no_to", o_timeout, 0);
        req = '0;
        step();
        check("wd_edge_no_to_late", o_timeout, 0);

        // initDone lost mid-write: abort without ack, regrant when it returns.
        req = 4'b0100;
        wait_start("init_drop_start");
        step();
        init_done = 1'b0;
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("init_drop_state", o_dbg_state, ST_WAIT_INIT);
        check("init_drop_no_ack", o_ack, 0);
        step();
        check("init_drop_hold", o_dbg_state, ST_WAIT_INIT);
        init_done = 1'b1;
        step();
        check("init_back_idle", o_dbg_state, ST_IDLE);
        wait_start("regrant_start");
        check("regrant_owner", o_owner, 2);
        ack_cycle("regrant_ack", 4'b0100);
        req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
